// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction-memory request/ready port used by the fetch stage.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : word-aligned fetch address (fetch -> memory)
//   imem_ready : read data valid this cycle (memory -> fetch)
//   imem_rdata : instruction word (memory -> fetch)
// modport master : the fetch stage side
// modport slave  : the instruction-memory side
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, drives the
// instruction-memory port, honours the hazard stall (pc_write) and applies
// jr > jump > branch redirects resolved in ID. Emits an all-zero bubble when
// no valid instruction is available.
//
// Parameters:
//   RESET_PC      : PC loaded on reset (word aligned)
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset
//   pc_write      : 1 = PC may advance, 0 = hold current fetch
//   branch_taken / branch_target : taken branch redirect
//   jump / jump_target           : j/jal redirect
//   jr / jr_target               : jr/jalr redirect
//   imem          : instruction-memory port (master side)
//   is            : instruction to IF/ID (0 when fetch_valid=0)
//   pc_plus4F     : address of delivered instruction + 4
//   fetch_valid   : is carries a real instruction
// Optional (macro IF_PERF_CNT_EN):
//   fetch_cnt     : cycles with fetch_valid & pc_write
//   bubble_cnt    : cycles out of reset with fetch_valid = 0
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pc_write,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   jump,
    input  logic [31:0]            jump_target,
    input  logic                   jr,
    input  logic [31:0]            jr_target,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            is,
    output logic [31:0]            pc_plus4F,
    output logic                   fetch_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        redirect;
    logic [31:0] target;
    logic        req_c;
    logic        valid_c;
    logic [31:0] is_c;

    assign redirect = jr | jump | branch_taken;

    always_comb begin
        target = branch_target;
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = jump_target;
        end
        target[1:0] = 2'b00;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        pend_pc_d = pend_pc_q;
        req_c     = 1'b0;
        valid_c   = 1'b0;
        is_c      = '0;

        unique case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (imem.imem_ready) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (pc_write) begin
                        is_c    = imem.imem_rdata;
                        valid_c = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end else begin
                        is_c    = imem.imem_rdata;
                        valid_c = 1'b1;
                        buf_d   = imem.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay put until the outstanding read lands.
                    pend_pc_d = target;
                    state_d   = DRAIN;
                end
            end
            HOLD: begin
                is_c    = buf_q;
                valid_c = 1'b1;
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (pc_write) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                req_c = 1'b1;
                if (redirect) begin
                    pend_pc_d = target;
                end
                if (imem.imem_ready) begin
                    pc_d    = redirect ? target : pend_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            buf_q     <= '0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Gated with reset so the memory sees req drop the moment reset asserts.
    assign imem.imem_req  = reset & req_c;
    assign imem.imem_addr = pc_q;
    assign is             = reset ? is_c : '0;
    assign fetch_valid    = reset & valid_c;
    assign pc_plus4F      = pc_q + 32'd4;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (fetch_valid && pc_write) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (!fetch_valid && reset) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Scenario bench for if_fetch_stage. Each scenario is a table of per-cycle
// stimulus plus the expected fetch outputs; expectations are queued when the
// stimulus is driven and popped when outputs are sampled on the falling edge.
// Memory model: combinational, word at address a is a ^ 32'hC0DE_0000.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        ready;
    logic        force_rd;
    logic [31:0] is_o;
    logic [31:0] pc_plus4F;
    logic        fetch_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;
    int unsigned exp_fetch  = 0;
    int unsigned exp_bubble = 0;

    logic [128:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    if_fetch_stage_if imem ();

    assign imem.imem_ready = ready;
    assign imem.imem_rdata = force_rd ? 32'hDEAD_BEEF : word_at(imem.imem_addr);

    if_fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem          (imem.master),
        .is            (is_o),
        .pc_plus4F     (pc_plus4F),
        .fetch_valid   (fetch_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    typedef struct {
        logic        pw;
        logic        rdy;
        logic [2:0]  sel;   // {jr, jump, branch_taken}
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] rt;
        logic        frd;
        logic        req;
        logic [31:0] addr;  // compared only while req=1
        logic        vld;
        logic [31:0] isv;
        logic [31:0] pc4;
    } step_t;

    function automatic step_t st(input logic pw, input logic rdy, input logic [2:0] sel,
                                 input logic [31:0] bt, input logic [31:0] jt,
                                 input logic [31:0] rt, input logic frd,
                                 input logic req, input logic [31:0] addr,
                                 input logic vld, input logic [31:0] isv,
                                 input logic [31:0] pc4);
        step_t s;
        s.pw = pw; s.rdy = rdy; s.sel = sel; s.bt = bt; s.jt = jt; s.rt = rt;
        s.frd = frd; s.req = req; s.addr = req ? addr : 32'h0; s.vld = vld;
        s.isv = isv; s.pc4 = pc4;
        return s;
    endfunction

    function automatic logic [128:0] observed();
        return {imem.imem_req, (imem.imem_req ? imem.imem_addr : 32'h0),
                fetch_valid, is_o, pc_plus4F};
    endfunction

    // Drives one cycle of stimulus and queues what the fetch outputs must be.
    task automatic apply(input step_t s);
        pc_write      = s.pw;
        ready         = s.rdy;
        jr            = s.sel[2];
        jump          = s.sel[1];
        branch_taken  = s.sel[0];
        branch_target = s.bt;
        jump_target   = s.jt;
        jr_target     = s.rt;
        force_rd      = s.frd;
        sb.push_back({s.req, s.addr, s.vld, s.isv, s.pc4});
        if (s.vld && s.pw) exp_fetch++;
        if (!s.vld) exp_bubble++;
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [128:0] e;
        logic [128:0] o;
        reset = 1'b0;
        apply(st(1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_run++;
        if (imem.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", imem.imem_req);
        end
        n_run++;
        if (fetch_valid !== 1'b0 || is_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_is: got valid=%b is=%h want 0/0", fetch_valid, is_o);
        end
        n_run++;
        if (pc_plus4F !== 32'h3004) begin
            n_fail++; $display("FAIL reset_pc4: got %h want 00003004", pc_plus4F);
        end
`ifdef IF_PERF_CNT_EN
        n_run++;
        if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", fetch_cnt, bubble_cnt);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        exp_fetch = 0; exp_bubble = 0;
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3000, 1, word_at(32'h3000), 32'h3004));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3004, 1, word_at(32'h3004), 32'h3008));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); o = observed(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL release step %0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        step_t s[$];
        logic [128:0] e;
        logic [128:0] o;
        s.push_back(st(0, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3008, 1, word_at(32'h3008), 32'h300C));
        s.push_back(st(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        1, word_at(32'h3008), 32'h300C));
        s.push_back(st(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        1, word_at(32'h3008), 32'h300C));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 0, 0,        1, word_at(32'h3008), 32'h300C));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h300C, 1, word_at(32'h300C), 32'h3010));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); o = observed(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL stall step %0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_not_ready();
        step_t s[$];
        logic [128:0] e;
        logic [128:0] o;
        s.push_back(st(1, 0, 3'b000, 0, 0, 0, 0, 1, 32'h3010, 0, 32'h0, 32'h3014));
        s.push_back(st(1, 0, 3'b000, 0, 0, 0, 0, 1, 32'h3010, 0, 32'h0, 32'h3014));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3010, 1, word_at(32'h3010), 32'h3014));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3014, 1, word_at(32'h3014), 32'h3018));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3018, 1, word_at(32'h3018), 32'h301C));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h301C, 1, word_at(32'h301C), 32'h3020));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); o = observed(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL not_ready step %0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain();
        step_t s[$];
        logic [128:0] e;
        logic [128:0] o;
        s.push_back(st(1, 0, 3'b010, 0, 32'h3500, 0, 0, 1, 32'h3020, 0, 32'h0, 32'h3024));
        s.push_back(st(1, 0, 3'b000, 0, 0,        0, 0, 1, 32'h3020, 0, 32'h0, 32'h3024));
        s.push_back(st(1, 1, 3'b000, 0, 0,        0, 1, 1, 32'h3020, 0, 32'h0, 32'h3024));
        s.push_back(st(1, 1, 3'b000, 0, 0,        0, 0, 1, 32'h3500, 1, word_at(32'h3500), 32'h3504));
        // second drain: the later redirect replaces the pending target
        s.push_back(st(1, 0, 3'b001, 32'h3600, 0, 0, 0, 1, 32'h3504, 0, 32'h0, 32'h3508));
        s.push_back(st(1, 0, 3'b010, 0, 32'h3700, 0, 0, 1, 32'h3504, 0, 32'h0, 32'h3508));
        s.push_back(st(1, 1, 3'b000, 0, 0,        0, 0, 1, 32'h3504, 0, 32'h0, 32'h3508));
        s.push_back(st(1, 1, 3'b000, 0, 0,        0, 0, 1, 32'h3700, 1, word_at(32'h3700), 32'h3704));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); o = observed(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL drain step %0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        step_t s[$];
        logic [128:0] e;
        logic [128:0] o;
        s.push_back(st(1, 1, 3'b011, 32'h3100, 32'h3400, 0, 0, 1, 32'h3704, 0, 32'h0, 32'h3708));
        s.push_back(st(1, 1, 3'b111, 32'h3100, 32'h3400, 32'h3202, 0, 1, 32'h3400, 0, 32'h0, 32'h3404));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3200, 1, word_at(32'h3200), 32'h3204));
        // redirect wins over a stall
        s.push_back(st(0, 1, 3'b001, 32'h3300, 0, 0, 0, 1, 32'h3204, 0, 32'h0, 32'h3208));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3300, 1, word_at(32'h3300), 32'h3304));
        // redirect out of HOLD
        s.push_back(st(0, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3304, 1, word_at(32'h3304), 32'h3308));
        s.push_back(st(0, 1, 3'b001, 32'h3800, 0, 0, 0, 0, 0, 1, word_at(32'h3304), 32'h3308));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3800, 1, word_at(32'h3800), 32'h3804));
        // top-of-memory wrap with an unaligned target
        s.push_back(st(1, 1, 3'b010, 0, 32'hFFFF_FFFF, 0, 0, 1, 32'h3804, 0, 32'h0, 32'h3808));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, word_at(32'hFFFF_FFFC), 32'h0));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h0, 1, word_at(32'h0), 32'h4));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); o = observed(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL redirect step %0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        step_t s[$];
        logic [128:0] e;
        logic [128:0] o;
        s.push_back(st(1, 0, 3'b010, 0, 32'h3500, 0, 0, 1, 32'h4, 0, 32'h0, 32'h8));
        s.push_back(st(1, 0, 3'b000, 0, 0,        0, 0, 1, 32'h4, 0, 32'h0, 32'h8));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); o = observed(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL mid_drain step %0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
`ifdef IF_PERF_CNT_EN
        n_run++;
        if (fetch_cnt !== exp_fetch) begin
            n_fail++; $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, exp_fetch);
        end
        n_run++;
        if (bubble_cnt !== exp_bubble) begin
            n_fail++; $display("FAIL bubble_cnt: got %0d want %0d", bubble_cnt, exp_bubble);
        end
`endif
        #2;
        reset = 1'b0;
        #1;
        n_run++;
        if (imem.imem_req !== 1'b0 || fetch_valid !== 1'b0 || is_o !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b valid=%b is=%h want 0/0/0",
                     imem.imem_req, fetch_valid, is_o);
        end
        n_run++;
        if (pc_plus4F !== 32'h3004) begin
            n_fail++; $display("FAIL async_reset_pc4: got %h want 00003004", pc_plus4F);
        end
        @(posedge clk); #1;
`ifdef IF_PERF_CNT_EN
        n_run++;
        if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin
            n_fail++; $display("FAIL cnt_cleared: got %h/%h want 0/0", fetch_cnt, bubble_cnt);
        end
`endif
        reset = 1'b1;
        exp_fetch = 0; exp_bubble = 0;
        s.delete();
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3000, 1, word_at(32'h3000), 32'h3004));
        s.push_back(st(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h3004, 1, word_at(32'h3004), 32'h3008));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); o = observed(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL after_reset step %0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_not_ready();
        test_drain();
        test_redirect();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
